// File: rtl/duck_target_sequencer.sv
// duck_target_sequencer: sole bus initiator for the game RAM. Waits for the
// game-active word, lights a pseudo-random target LED, polls its
// phototransistor until a hit or a timeout, turns the LED off, publishes the
// running score, then rests for a gap before the next target.
module duck_target_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 12,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES     = 25000000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut,
  output logic [15:0]              score,
  output logic [15:0]              misses,
  output logic [3:0]               active_target,
  output logic                     busy
);

  localparam logic [ADDRESS_WIDTH-1:0] GAME_ADDR  = ADDRESS_WIDTH'(5);
  localparam logic [ADDRESS_WIDTH-1:0] SCORE_ADDR = ADDRESS_WIDTH'(6);
  localparam logic [ADDRESS_WIDTH-1:0] LED_BASE   = ADDRESS_WIDTH'(10);
  localparam logic [31:0]              TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]              GAP_LAST     = 32'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_IDLE_WAIT,
    S_PICK,
    S_LED_ON,
    S_POLL,
    S_POLL_WAIT,
    S_LED_OFF,
    S_SCORE_WR,
    S_GAP
  } state_t;

  state_t state;
  state_t next_state;

  logic [15:0]              lfsr;
  logic                     lfsr_fb;
  logic [1:0]               idx;
  logic [31:0]              tcnt;
  logic [31:0]              gcnt;
  logic                     game_prev;
  logic                     rd_bit;
  logic                     timed_out;
  logic [ADDRESS_WIDTH-1:0] led_addr;
  logic [ADDRESS_WIDTH-1:0] pt_addr;
  logic                     wen;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    din;
  logic                     unused_data;

  // Only bit 0 of any word this block reads carries meaning.
  assign rd_bit      = mem_dataOut[0];
  assign unused_data = ^mem_dataOut[DATA_WIDTH-1:1];

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign timed_out = (tcnt >= TIMEOUT_LAST);
  assign led_addr  = LED_BASE + ADDRESS_WIDTH'({idx, 1'b0});
  assign pt_addr   = led_addr + ADDRESS_WIDTH'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus-request decode; *_WAIT states hold the read address.
  always_comb begin
    next_state = state;
    wen        = 1'b0;
    addr       = '0;
    din        = '0;
    case (state)
      S_IDLE: begin
        if (en) begin
          addr       = GAME_ADDR;
          next_state = S_IDLE_WAIT;
        end
      end
      S_IDLE_WAIT: begin
        addr = GAME_ADDR;
        if (en && rd_bit) begin
          next_state = S_PICK;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_PICK: begin
        next_state = S_LED_ON;
      end
      S_LED_ON: begin
        wen        = 1'b1;
        addr       = led_addr;
        din        = DATA_WIDTH'(1);
        next_state = S_POLL;
      end
      S_POLL: begin
        addr       = pt_addr;
        next_state = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        addr = pt_addr;
        if (rd_bit || timed_out) begin
          next_state = S_LED_OFF;
        end else begin
          next_state = S_POLL;
        end
      end
      S_LED_OFF: begin
        wen        = 1'b1;
        addr       = led_addr;
        next_state = S_SCORE_WR;
      end
      S_SCORE_WR: begin
        wen        = 1'b1;
        addr       = SCORE_ADDR;
        din        = DATA_WIDTH'(score);
        next_state = S_GAP;
      end
      S_GAP: begin
        if (!en || (gcnt >= GAP_LAST)) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Bus outputs are forced low for the whole time reset is asserted, not
  // just from the next edge, so a write in flight is cut off at once.
  assign mem_wEn    = reset ? 1'b0 : wen;
  assign mem_addr   = reset ? '0 : addr;
  assign mem_dataIn = reset ? '0 : din;
  assign busy       = (state != S_IDLE) && (state != S_IDLE_WAIT);

  // Target selection, timers, game-edge detection and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr          <= LFSR_SEED;
      idx           <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      game_prev     <= 1'b0;
      score         <= '0;
      misses        <= '0;
      active_target <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        S_IDLE_WAIT: begin
          if (en) begin
            game_prev <= rd_bit;
            if (rd_bit && !game_prev) begin
              score  <= '0;
              misses <= '0;
            end
          end
        end
        S_PICK: begin
          idx           <= lfsr[1:0];
          active_target <= 4'b0001 << lfsr[1:0];
          tcnt          <= '0;
        end
        S_LED_ON, S_POLL: begin
          tcnt <= tcnt + 32'd1;
        end
        S_POLL_WAIT: begin
          tcnt <= tcnt + 32'd1;
          // A hit seen on the final poll still counts as a hit.
          if (rd_bit) begin
            if (score != '1) score <= score + 16'd1;
          end else if (timed_out) begin
            if (misses != '1) misses <= misses + 16'd1;
          end
        end
        S_LED_OFF: begin
          active_target <= '0;
        end
        S_SCORE_WR: begin
          gcnt <= '0;
        end
        S_GAP: begin
          gcnt <= gcnt + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
